// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL lock supervisor / reset sequencer.
//   pll_state_t : sequencer states (PLLRST, WAIT, HOLD, RUN)
//   FAULT_W     : width of the saturating fault counter
//   max3        : largest of three integers, used to size the shared counter
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } pll_state_t;

  localparam int FAULT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// One-bit, two-flop synchronizer for asynchronous status inputs.
// Both flops clear on the synchronous reset.
//   clk : destination clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input bit
//   q   : input bit synchronized to clk (two cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Lock supervisor and reset sequencer for the core PLL. Runs on the free-running
// reference clock, pulses the PLL reset, waits for lock, requires lock to stay
// stable for a hold time before releasing the core reset, and retries the PLL
// whenever lock is not reached in time or is lost.
//   clk          : reference clock (same net as the PLL refclk, never a PLL output)
//   rst          : synchronous, active-high reset; restarts the full sequence
//   locked_async : PLL locked output, asynchronous to clk
//   soft_reset   : re-reset the core (not the PLL) while running
//   pll_rst      : drives the PLL rst input
//   core_rst     : active-high reset for core clock domains
//   ready        : high only while running
//   fault_cnt    : saturating count of lock timeouts plus lock losses
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STABLE_CYC       = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_async,
  input  logic               soft_reset,
  output logic               pll_rst,
  output logic               core_rst,
  output logic               ready,
  output logic [FAULT_W-1:0] fault_cnt
);

  localparam int CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);

  logic locked_s;

  pll_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [FAULT_W-1:0] fault_reg, fault_next;
  logic               fault_inc;

  // The only consumer of locked_async.
  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked_async),
    .q   (locked_s)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    fault_inc  = 1'b0;

    unique case (state_reg)
      PLLRST: begin
        if (cnt_reg == RST_LAST) state_next = WAIT;
      end
      WAIT: begin
        // Lock seen on the final cycle wins over the timeout.
        if (locked_s) begin
          state_next = HOLD;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = PLLRST;
          fault_inc  = 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_next = PLLRST;
          fault_inc  = 1'b1;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!locked_s) begin
          state_next = PLLRST;
          fault_inc  = 1'b1;
        end else if (soft_reset) begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = PLLRST;
      end
    endcase

    // Every state starts timing from zero. In RUN the counter free-runs and
    // may wrap; nothing looks at it there.
    if (state_next != state_reg) cnt_next = '0;

    fault_next = fault_reg;
    if (fault_inc && (fault_reg != {FAULT_W{1'b1}})) fault_next = fault_reg + FAULT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PLLRST;
      cnt_reg   <= '0;
      fault_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
    end
  end

  // Moore outputs from the registered state only.
  assign pll_rst   = (state_reg == PLLRST);
  assign core_rst  = (state_reg != RUN);
  assign ready     = (state_reg == RUN);
  assign fault_cnt = fault_reg;

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Lock supervisor and reset sequencer for the core PLL. It runs on the free-running 50 MHz reference clock and drives the PLL's `rst` input. It watches the PLL's asynchronous `locked` output, retries the PLL when lock is not reached or is lost, and releases the core reset only after lock has been stable for a programmable hold time. It sits between the PLL wrapper and every core block that consumes `outclk_*`.

## Interface
- `RST_PULSE_CYC`, 16: width of each PLL reset pulse, in clk cycles (≥2).
- `LOCK_TIMEOUT_CYC`, 65536: cycles to wait for lock after a PLL reset before retrying (≥2).
- `STABLE_CYC`, 1024: cycles lock must stay high before core reset is released (≥2).
- `clk` in 1: 50 MHz reference clock, the same net that feeds the PLL's `refclk`. It must not be a PLL output.
- `rst` in 1: synchronous, active-high.
- `locked_async` in 1: PLL `locked`. Asynchronous to `clk`.
- `soft_reset` in 1: single-cycle or level request to re-reset the core without resetting the PLL.
- `pll_rst` out 1: connects to the PLL's `rst`.
- `core_rst` out 1: active-high reset for the core clock domains. Each consumer re-synchronizes it.
- `ready` out 1: high only in RUN.
- `fault_cnt` out 8: saturating count of lock timeouts plus lock losses.

## Operation
- `locked_async` passes through a 2-FF synchronizer to produce `locked_s`. No other logic samples `locked_async`.
- A single counter `cnt` is sized `$clog2` of the largest parameter. It clears on every state change.
- States:
  - PLLRST: `pll_rst`=1. When `cnt`==`RST_PULSE_CYC`-1, go to WAIT.
  - WAIT: `pll_rst`=0. If `locked_s`, go to HOLD. Otherwise, when `cnt`==`LOCK_TIMEOUT_CYC`-1, go to PLLRST and increment `fault_cnt`. `locked_s` is checked before the timeout.
  - HOLD: If `!locked_s`, go to PLLRST and increment `fault_cnt`. Otherwise, when `cnt`==`STABLE_CYC`-1, go to RUN.
  - RUN: If `!locked_s`, go to PLLRST and increment `fault_cnt`. Otherwise, if `soft_reset`, go to HOLD.
- Priority: lock loss beats `soft_reset`. `soft_reset` is ignored outside RUN.
- Outputs are Moore, decoded from the registered state:
  - `core_rst` = (state≠RUN).
  - `ready` = (state==RUN).
  - `pll_rst` = (state==PLLRST).
- `fault_cnt` saturates at 255 and does not wrap. It is cleared only by `rst`.
- On `rst`, including mid-sequence:
  - state=PLLRST, `cnt`=0, synchronizer flops=0, `fault_cnt`=0.
  - Outputs: `pll_rst`=1, `core_rst`=1, `ready`=0.
  - A full PLL reset sequence then restarts.

## Timing
- Let t0 be the first edge that samples `locked_async`=1 (or =0 for a loss).
  - `locked_s` changes at t1.
  - The state transition is registered at t2.
  - Outputs reflect the new state from t2.
- Lock acquisition: HOLD is entered at t2 and RUN at t2+`STABLE_CYC`. `core_rst` falls and `ready` rises at that edge.
- Lock loss in RUN: `core_rst`=1, `ready`=0 and `pll_rst`=1 at t2. `fault_cnt` updates at t2.
- Pulse widths:
  - `pll_rst` is high for exactly `RST_PULSE_CYC` cycles per entry to PLLRST.
  - With no lock, the retry period is `RST_PULSE_CYC`+`LOCK_TIMEOUT_CYC` cycles.
- `soft_reset` sampled high in RUN at edge e: `core_rst`=1 from e and for exactly `STABLE_CYC` cycles, assuming lock holds.
- A `locked_async` glitch shorter than one clk period may or may not be captured. Either outcome is legal, but a captured glitch must produce the full loss behaviour.

## Structure
- `pll_ctrl_pkg` contains:
  - the state enum: PLLRST, WAIT, HOLD, RUN;
  - the `FAULT_W`=8 constant;
  - a `max3` helper function for counter sizing.
- Sub-module `sync_2ff`: a 1-bit, 2-flop synchronizer with synchronous reset. It is reused elsewhere for other asynchronous status bits.
- The FSM, counter and fault counter live in one `always` block. Output decode is combinational.

## Test plan
All scenarios use `RST_PULSE_CYC`=4, `LOCK_TIMEOUT_CYC`=32, `STABLE_CYC`=8.

1. Release `rst`, raise `locked_async` 10 cycles later:
   - `pll_rst` is high for exactly 4 cycles.
   - `core_rst` falls and `ready` rises at t0+10.
   - `fault_cnt`=0.
2. `locked_async` held 0:
   - `pll_rst` pulses 4 cycles wide with a 36-cycle period.
   - `fault_cnt` reads 1, 2, 3 after each timeout.
3. In RUN, drop `locked_async` for 3 cycles, then restore it:
   - `core_rst`=1, `ready`=0 and `pll_rst`=1 at t0+2.
   - `fault_cnt`=1.
   - Lock is re-acquired and RUN is re-entered.
4. In HOLD at `cnt`=5, drop lock:
   - The sequence returns to PLLRST; RUN is never reached.
   - `fault_cnt` increments by 1.
   - After lock returns, HOLD restarts from `cnt`=0 and lasts a full 8 cycles.
5. `soft_reset` pulse in RUN:
   - `core_rst` is high exactly 8 cycles.
   - `pll_rst` stays 0.
   - `fault_cnt` is unchanged.
6. Concurrency and counter limits:
   - `soft_reset` in the same cycle `locked_s` falls: the FSM goes to PLLRST and `fault_cnt` increments.
   - 300 forced timeouts: `fault_cnt` holds at 255.
   - `rst` asserted mid-HOLD: all outputs return to their reset values next cycle and `fault_cnt`=0.
